// File: rtl/bitmanip_pkg.sv
// Shared encodings for the bit-manipulation unit: operation modes, FSM states
// and the helper that splits modes into single-cycle logic ops and multi-cycle count ops.
package bitmanip_pkg;

  typedef enum logic [3:0] {
    MODE_AND  = 4'd0,
    MODE_OR   = 4'd1,
    MODE_XOR  = 4'd2,
    MODE_ANDN = 4'd3,
    MODE_ORN  = 4'd4,
    MODE_XNOR = 4'd5,
    MODE_CLZ  = 4'd6,
    MODE_CTZ  = 4'd7,
    MODE_CPOP = 4'd8
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_count_mode(input logic [3:0] mode);
    return (mode == MODE_CLZ) || (mode == MODE_CTZ) || (mode == MODE_CPOP);
  endfunction

endpackage

// File: rtl/bit_count_step.sv
// Combinational per-chunk counters: popcount, leading zeros, trailing zeros and
// an all-zero flag for one W-bit slice of the operand.
module bit_count_step #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  chunk,
  output logic [CW-1:0] pop,
  output logic [CW-1:0] lz,
  output logic [CW-1:0] tz,
  output logic          all_zero
);

  always_comb begin
    pop = '0;
    lz  = CW'(W);
    tz  = CW'(W);
    // Ascending scan leaves lz at the highest set bit; descending leaves tz at the lowest.
    for (int i = 0; i < W; i++) begin
      pop = pop + CW'(chunk[i]);
      if (chunk[i]) lz = CW'(W - 1 - i);
    end
    for (int i = W - 1; i >= 0; i--) begin
      if (chunk[i]) tz = CW'(i);
    end
    all_zero = ~|chunk;
  end

endmodule

// File: rtl/bitmanip_unit.sv
// Bit-manipulation unit: single-cycle logic ops and fixed-latency CLZ/CTZ/CPOP
// that walk the captured operand CNT_STEP bits per cycle, with valid/ready on both sides.
module bitmanip_unit
  import bitmanip_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int CNT_STEP = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3:0]      i_mode,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);

  localparam int NCHUNK  = XLEN / CNT_STEP;
  localparam int ACC_W   = $clog2(XLEN) + 1;
  localparam int CNT_W   = $clog2(NCHUNK + 1);
  localparam int STEP_CW = $clog2(CNT_STEP + 1);

  generate
    if ((CNT_STEP < 1) || (XLEN % CNT_STEP != 0)) begin : g_param_check
      $error("bitmanip_unit: XLEN must be a multiple of CNT_STEP and CNT_STEP >= 1");
    end
  endgenerate

  state_e             state;
  logic [3:0]         op_mode;
  logic [XLEN-1:0]    opa;
  logic [ACC_W-1:0]   acc;
  logic               found;
  logic [CNT_W-1:0]   step_cnt;

  logic [XLEN-1:0]    logic_res;
  logic               accept;
  logic [CNT_STEP-1:0] chunk;
  logic [STEP_CW-1:0] chunk_pop, chunk_lz, chunk_tz;
  logic               chunk_zero;
  logic [ACC_W-1:0]   acc_next;
  logic               found_next;

  assign o_ready = (state == ST_IDLE) || ((state == ST_DONE) && i_ready);
  assign o_valid = (state == ST_DONE);
  assign accept  = i_valid && o_ready;

  always_comb begin
    case (i_mode)
      MODE_AND:  logic_res = i_a & i_b;
      MODE_OR:   logic_res = i_a | i_b;
      MODE_XOR:  logic_res = i_a ^ i_b;
      MODE_ANDN: logic_res = i_a & ~i_b;
      MODE_ORN:  logic_res = i_a | ~i_b;
      MODE_XNOR: logic_res = ~(i_a ^ i_b);
      default:   logic_res = '0;
    endcase
  end

  // CLZ consumes the operand from the top (shifting left), CTZ/CPOP from the bottom.
  assign chunk = (op_mode == MODE_CLZ) ? opa[XLEN-1 -: CNT_STEP] : opa[CNT_STEP-1:0];

  bit_count_step #(.W(CNT_STEP)) u_step (
    .chunk    (chunk),
    .pop      (chunk_pop),
    .lz       (chunk_lz),
    .tz       (chunk_tz),
    .all_zero (chunk_zero)
  );

  always_comb begin
    acc_next   = acc;
    found_next = found;
    if (op_mode == MODE_CPOP) begin
      acc_next = acc + ACC_W'(chunk_pop);
    end else if (!found) begin
      acc_next   = acc + ACC_W'((op_mode == MODE_CLZ) ? chunk_lz : chunk_tz);
      found_next = !chunk_zero;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      op_mode  <= '0;
      opa      <= '0;
      acc      <= '0;
      found    <= 1'b0;
      step_cnt <= '0;
      o_result <= '0;
    end else begin
      case (state)
        ST_CALC: begin
          acc      <= acc_next;
          found    <= found_next;
          step_cnt <= step_cnt + 1'b1;
          opa      <= (op_mode == MODE_CLZ) ? (opa << CNT_STEP) : (opa >> CNT_STEP);
          if (step_cnt == CNT_W'(NCHUNK - 1)) begin
            o_result <= XLEN'(acc_next);
            state    <= ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_count_mode(i_mode)) begin
              op_mode  <= i_mode;
              opa      <= i_a;
              acc      <= '0;
              found    <= 1'b0;
              step_cnt <= '0;
              state    <= ST_CALC;
            end else begin
              o_result <= logic_res;
              state    <= ST_DONE;
            end
          end else if ((state == ST_DONE) && i_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitmanip_unit.sv
// Scoreboard bench for bitmanip_unit: directed cases plus randomized traffic
// checked against a behavioural model, with random consumer backpressure.
module tb_bitmanip_unit;

  localparam int XLEN      = 32;
  localparam int CNT_STEP  = 8;
  localparam int COUNT_LAT = XLEN / CNT_STEP + 1;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic            i_valid  = 1'b0;
  logic            i_ready  = 1'b1;
  logic [3:0]      i_mode   = 4'd0;
  logic [XLEN-1:0] i_a      = '0;
  logic [XLEN-1:0] i_b      = '0;
  logic            o_ready;
  logic            o_valid;
  logic [XLEN-1:0] o_result;

  typedef struct {
    logic [31:0] res;
    int          acc_cyc;
    int          lat;
    logic [3:0]  mode;
  } exp_t;

  exp_t sb[$];
  int   tests     = 0;
  int   fails     = 0;
  int   cyc       = 0;
  bit   rand_rdy  = 1'b0;
  bit   rdy_force = 1'b1;

  bitmanip_unit #(.XLEN(XLEN), .CNT_STEP(CNT_STEP)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_mode   (i_mode),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [3:0] m, input logic [31:0] x, input logic [31:0] y);
    int n;
    n = 0;
    case (m)
      4'd0: return x & y;
      4'd1: return x | y;
      4'd2: return x ^ y;
      4'd3: return x & ~y;
      4'd4: return x | ~y;
      4'd5: return ~(x ^ y);
      4'd6: begin
        for (int i = XLEN - 1; i >= 0; i--) begin
          if (x[i]) break;
          n++;
        end
        return 32'(n);
      end
      4'd7: begin
        for (int i = 0; i < XLEN; i++) begin
          if (x[i]) break;
          n++;
        end
        return 32'(n);
      end
      4'd8: return 32'($countones(x));
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] m);
    return (m >= 4'd6 && m <= 4'd8) ? COUNT_LAT : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Consumer-side ready: random when enabled, otherwise the directed value.
  initial forever begin
    @(posedge clk);
    #1;
    i_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // Monitor: pops the scoreboard on every handshake, checks hold stability under backpressure.
  logic [31:0] held = '0;
  bit          presenting = 1'b0;
  int          since = 0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      presenting = 1'b0;
    end else if (o_valid) begin
      if (!presenting) since = cyc;
      else check("hold_stable", o_result, held);
      check("ready_follows_i_ready", 32'(o_ready), 32'(i_ready));
      if (i_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got 0x%08h, expected no result", o_result);
        end else begin
          e = sb.pop_front();
          check($sformatf("result_mode%0d", e.mode), o_result, e.res);
          check($sformatf("latency_mode%0d", e.mode), 32'(since - e.acc_cyc), 32'(e.lat));
        end
        presenting = 1'b0;
      end else begin
        presenting = 1'b1;
        held = o_result;
      end
    end else begin
      presenting = 1'b0;
    end
  end

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] m, input logic [31:0] x, input logic [31:0] y);
    int   waited;
    exp_t e;
    waited  = 0;
    i_valid = 1'b1;
    i_mode  = m;
    i_a     = x;
    i_b     = y;
    @(negedge clk);
    while (!o_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!o_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: o_ready=%0b after %0d cycles, expected 1", o_ready, waited);
    end else begin
      e.res     = model(m, x, y);
      e.acc_cyc = cyc;
      e.lat     = lat_of(m);
      e.mode    = m;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_mode  = 4'($urandom);
    i_a     = $urandom;
    i_b     = $urandom;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h1 << $urandom_range(0, 31);
      3:       return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_o_valid", 32'(o_valid), 32'd0);
    check("reset_o_ready", 32'(o_ready), 32'd1);
    check("reset_o_result", o_result, 32'd0);
    rst_n = 1'b1;

    issue(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    issue(4'd6, 32'h0001_0000, $urandom);
    for (int i = 0; i < COUNT_LAT - 1; i++) begin
      @(negedge clk);
      check("calc_o_ready", 32'(o_ready), 32'd0);
      check("calc_o_valid", 32'(o_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    issue(4'd6, 32'h0, $urandom);
    issue(4'd7, 32'h8000_0000, $urandom);
    issue(4'd8, 32'hFFFF_FFFF, $urandom);
    issue(4'd8, 32'h0, $urandom);
    issue(4'd7, 32'h0, $urandom);
    issue(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(4'd3, 32'hFFFF_0000, 32'hFF00_FF00);
    issue(4'd4, 32'h0F0F_0000, 32'h00FF_00FF);

    // Backpressure: XNOR held three cycles, then a waiting AND goes in on release.
    wait_drain();
    #1 rdy_force = 1'b0;
    @(posedge clk);
    #1;
    issue(4'd5, 32'h1234_5678, 32'h1234_5678);
    fork
      begin
        repeat (2) @(posedge clk);
        #2 rdy_force = 1'b1;
      end
      issue(4'd0, $urandom, $urandom);
    join

    // Reset during the second CALC cycle of a CPOP.
    wait_drain();
    issue(4'd8, 32'hDEAD_BEEF, $urandom);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_o_valid", 32'(o_valid), 32'd0);
    check("abort_o_ready", 32'(o_ready), 32'd1);
    check("abort_o_result", o_result, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_result_after_abort", 32'(o_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    rand_rdy = 1'b1;
    for (int t = 0; t < 300; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      issue(4'($urandom_range(0, 15)), pick_operand(), pick_operand());
    end
    rand_rdy  = 1'b0;
    rdy_force = 1'b1;
    wait_drain();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bitmanip_unit.md
BITMANIP_UNIT -- requirements
Module: bitmanip_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width.
REQ-002 SHALL have parameter CNT_STEP, default 8: bits examined per cycle by count ops.
REQ-003 SHALL have port i_clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port i_valid, input, 1: request valid.
REQ-006 SHALL have port o_ready, output, 1: unit accepts request this cycle.
REQ-007 SHALL have port i_mode, input, 4: operation select.
REQ-008 SHALL have ports i_a and i_b, input, XLEN each: operands.
REQ-009 SHALL have port o_valid, output, 1: result valid.
REQ-010 SHALL have port i_ready, input, 1: consumer accepts result.
REQ-011 SHALL have port o_result, output, XLEN: registered result.

Function
REQ-012 SHALL decode i_mode as: 0 AND, 1 OR, 2 XOR, 3 ANDN (a & ~b), 4 ORN (a | ~b), 5 XNOR, 6 CLZ(a), 7 CTZ(a), 8 CPOP(a).
REQ-013 SHALL treat mode values 9-15 as logic-class ops with result 0.
REQ-014 SHALL accept a request on a cycle with i_valid and o_ready both high; all other i_valid cycles are ignored.
REQ-015 SHALL use FSM states IDLE, CALC and DONE.
REQ-016 IDLE: o_ready=1, o_valid=0.
REQ-017 CALC: o_ready=0, o_valid=0.
REQ-018 DONE: o_valid=1, o_ready=i_ready (combinational).
REQ-019 Logic-class accept SHALL register the result and go to DONE: o_valid high in the cycle after acceptance (latency 1).
REQ-020 Count-class accept (modes 6-8) SHALL capture i_a and go to CALC for exactly XLEN/CNT_STEP cycles, then DONE (latency XLEN/CNT_STEP+1; 5 at defaults).
REQ-021 Count latency SHALL be fixed regardless of operand value; there is no early exit.
REQ-022 CLZ SHALL scan chunks from the MSB, and CTZ from the LSB, with a sticky "found" flag; counting stops once a set bit is found.
REQ-023 CLZ(0) and CTZ(0) SHALL return XLEN.
REQ-024 CPOP SHALL accumulate the popcount of each chunk.
REQ-025 Count results SHALL be zero-extended to XLEN; the accumulator SHALL be $clog2(XLEN)+1 bits.
REQ-026 In DONE with i_ready=0, o_result and o_valid SHALL hold stable.
REQ-027 In DONE with i_ready=1 and no new accept, the FSM SHALL go to IDLE.
REQ-028 In DONE with i_ready=1 and a simultaneous accept, the FSM SHALL go directly to DONE (logic) or CALC (count), with no bubble.
REQ-029 Operand changes after acceptance SHALL not affect the in-flight result.
REQ-030 Parameters SHALL satisfy XLEN % CNT_STEP == 0 and CNT_STEP >= 1; a violation SHALL be an elaboration error.

Reset
REQ-031 Asserting i_rst_n low SHALL immediately set state=IDLE, o_valid=0, o_result=0, and clear the accumulator, found flag and captured operand.
REQ-032 Reset during CALC or DONE SHALL abort the operation; no result is delivered after release.
REQ-033 The first accept SHALL be possible on the first rising edge after i_rst_n deasserts.

Structure
REQ-034 Mode encodings, the FSM state type and the mode-class helper SHALL live in shared package bitmanip_pkg.
REQ-035 Per-chunk count logic SHALL be one combinational sub-module, bit_count_step (CNT_STEP-bit input; outputs popcount, leading-zero count, trailing-zero count, all-zero flag).
REQ-036 Logic ops SHALL be computed combinationally in the top module and registered only into o_result.

Verification
REQ-037 AND, a=0xF0F0F0F0, b=0xFF00FF00 -> o_result=0xF000F000, o_valid one cycle after accept.
REQ-038 CLZ, a=0x00010000 -> o_result=15, o_valid exactly 5 cycles after accept, o_ready=0 during CALC.
REQ-039 CLZ a=0 -> 32; CTZ a=0x80000000 -> 31; CPOP a=0xFFFFFFFF -> 32; CPOP a=0 -> 0.
REQ-040 Backpressure: XNOR a=b=0x12345678 with i_ready held low 3 cycles -> o_result=0xFFFFFFFF stable, o_valid high throughout; back-to-back accept on release with no bubble.
REQ-041 Reset mid-CALC (cycle 2 of CPOP) -> o_valid=0, state IDLE, and no result delivered after release.
REQ-042 Mode 4'hF, a=b=0xFFFFFFFF -> o_result=0 after 1 cycle; ANDN a=0xFFFF0000, b=0xFF00FF00 -> 0x00FF0000.
